// File: rtl/vector_prog_loader.sv
// Streams instruction words from a valid/ready source into the instruction memory
// write port, with a programmable base and count, an optional NOP pad and abort.
module vector_prog_loader #(
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter logic [INST_WIDTH-1:0] PAD_WORD = INST_WIDTH'(32'h00000013)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   count_i,
    input  logic                  mode_i,
    input  logic                  abort_i,
    input  logic                  s_valid_i,
    input  logic [INST_WIDTH-1:0] s_data_i,
    output logic                  s_ready_o,
    output logic                  inst_we_o,
    output logic [ADDR_WIDTH-1:0] inst_addr_o,
    output logic [INST_WIDTH-1:0] inst_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PAD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH+1:0] DEPTH_X   = (ADDR_WIDTH + 2)'(DEPTH);
    localparam logic [ADDR_WIDTH+1:0] LAST_X    = (ADDR_WIDTH + 2)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   ONE_CNT   = (ADDR_WIDTH + 1)'(1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     rem_q, rem_d;
    logic                    mode_q, mode_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [INST_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    hs;
    logic [ADDR_WIDTH+1:0]   end_x;
    logic [ADDR_WIDTH+1:0]   base_x;

    // Extra headroom bits keep the range check free of wrap-around.
    assign base_x = {2'b00, base_addr_i};
    assign end_x  = base_x + {1'b0, count_i};

    assign s_ready_o = (state_q == S_LOAD) & ~abort_i;
    assign hs        = s_valid_i & s_ready_o;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d = base_addr_i;
                    rem_d  = count_i;
                    mode_d = mode_i;
                    if (end_x > DEPTH_X) begin
                        err_d = 1'b1;
                    end else if (count_i == '0) begin
                        state_d = (mode_i && (base_x <= LAST_X)) ? S_PAD : S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (hs) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = s_data_i;
                    rem_d   = rem_q - ONE_CNT;
                    if (addr_q != LAST_ADDR) begin
                        addr_d = addr_q + 1'b1;
                    end
                    if (rem_q == ONE_CNT) begin
                        state_d = (mode_q && (addr_q < LAST_ADDR)) ? S_PAD : S_DONE;
                    end
                end
            end
            S_PAD: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = PAD_WORD;
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_LOAD) || (state_d == S_PAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            mode_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign inst_we_o   = we_q;
    assign inst_addr_o = waddr_q;
    assign inst_data_o = wdata_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule
